// File: rtl/i2s_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the I2S rate sequencer.
// Rate codes match the generator's s_rate input.
package i2s_ctrl_pkg;

   localparam logic [1:0] RATE_48K  = 2'd0;
   localparam logic [1:0] RATE_96K  = 2'd1;
   localparam logic [1:0] RATE_192K = 2'd2;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RUN_SETTLE,
      ST_LOCKED,
      ST_WAIT_FRAME
   } state_e;

   function automatic logic [1:0] norm_rate(input logic [1:0] r);
      return (r == 2'd3) ? RATE_192K : r;
   endfunction

endpackage

// File: rtl/i2s_lrclk_edge_det.sv
// LRCLK synchronizer with rise/fall pulses.
// Pulses are valid 2 SAICLK edges after the pin moves.
module i2s_lrclk_edge_det (
   input  logic SAICLK,
   input  logic reset,
   input  logic lrclk_in,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;
   logic [2:0] sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], lrclk_in};
   end

   always_ff @(posedge SAICLK or negedge reset) begin
      if (!reset) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   always_comb begin
      rise = sh_q[1] & ~sh_q[2];
      fall = ~sh_q[1] & sh_q[2];
   end

endmodule

// File: rtl/i2s_rate_sequencer.sv
// Glitch-safe sample-rate sequencer for the I2S clock generator.
// Holds the generator in reset around s_rate changes and watches LRCLK.
module i2s_rate_sequencer
   import i2s_ctrl_pkg::*;
#(
   parameter logic [1:0] DEFAULT_RATE   = 2'd0,
   parameter int         HOLD_CYCLES    = 8,
   parameter int         SETTLE_FRAMES  = 2,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       SAICLK,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [1:0] req_rate,
   output logic       req_ready,
   input  logic       lrclk_in,
   output logic       gen_reset_n,
   output logic [1:0] s_rate,
   output logic       locked,
   output logic       rate_done,
   output logic       err,
   input  logic       err_clr
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(SETTLE_FRAMES + 1);

   state_e          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [FW-1:0]   frm_q, frm_d;
   logic [1:0]      s_rate_q, s_rate_d;
   logic [1:0]      pend_q, pend_d;
   logic            err_q, err_d;
   logic            rd_q, rd_d;
   logic            rise, fall;
   logic            edge_any;
   logic            tmo_hit;
   logic [1:0]      req_norm;

   i2s_lrclk_edge_det u_edge (
      .SAICLK   (SAICLK),
      .reset    (reset),
      .lrclk_in (lrclk_in),
      .rise     (rise),
      .fall     (fall)
   );

   always_ff @(posedge SAICLK or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_HOLD;
         hold_q   <= '0;
         tmo_q    <= '0;
         frm_q    <= '0;
         s_rate_q <= DEFAULT_RATE;
         pend_q   <= DEFAULT_RATE;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         tmo_q    <= tmo_d;
         frm_q    <= frm_d;
         s_rate_q <= s_rate_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
      end
   end

   // An edge arriving in the expiry cycle still counts as activity.
   always_comb begin
      edge_any = rise | fall;
      tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !edge_any;
      req_norm = norm_rate(req_rate);
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = '0;
      tmo_d    = '0;
      frm_d    = '0;
      s_rate_d = s_rate_q;
      pend_d   = pend_q;
      err_d    = err_q;
      rd_d     = 1'b0;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (state_q != ST_HOLD && !edge_any) begin
         tmo_d = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
      end
      unique case (state_q)
         ST_HOLD: begin
            if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = ST_RUN_SETTLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RUN_SETTLE: begin
            frm_d = frm_q;
            if (tmo_hit) begin
               err_d   = 1'b1;
               frm_d   = '0;
               state_d = ST_HOLD;
            end else if (rise) begin
               if (frm_q == FW'(SETTLE_FRAMES - 1)) begin
                  frm_d   = '0;
                  rd_d    = 1'b1;
                  state_d = ST_LOCKED;
               end else begin
                  frm_d = frm_q + 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ST_HOLD;
            end else if (req_valid) begin
               if (req_norm == s_rate_q) begin
                  rd_d = 1'b1;
               end else begin
                  pend_d  = req_norm;
                  state_d = ST_WAIT_FRAME;
               end
            end
         end
         ST_WAIT_FRAME: begin
            if (fall || tmo_hit) begin
               s_rate_d = pend_q;
               state_d  = ST_HOLD;
               if (tmo_hit) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   // Ready is withheld in a watchdog cycle so an accepted request is never dropped.
   always_comb begin
      gen_reset_n = (state_q != ST_HOLD);
      locked      = (state_q == ST_LOCKED);
      req_ready   = (state_q == ST_LOCKED) && !tmo_hit;
      s_rate      = s_rate_q;
      rate_done   = rd_q;
      err         = err_q;
   end

endmodule
